// File: rtl/median_partition_stage.sv
// Quickselect partition stage for the median-filter actor chain.
// Pops one control token plus its pixel burst, splits the pixels into
// less / equal / greater regions of a single buffer, then either reports the
// rank-k value as found or forwards the region that holds rank k.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | wait for a complete control token, latch P / N / K
// FILL      | consume N pixels, partition into the buffer, track min/max
// DECIDE    | pick lt / eq / gt region, build the outgoing token
// EMIT_CTRL | push the outgoing token, prefetch first region pixel
// EMIT_PX   | stream the selected region out, one pixel per cycle
module median_partition_stage #(
    parameter int DATA_W    = 8,
    parameter int BUFF_SIZE = 1024,
    parameter int SIZE_W    = $clog2(BUFF_SIZE) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_px,
    output logic              in_px_rd,
    input  logic              in_px_empty,
    input  logic [DATA_W-1:0] in_pivot,
    input  logic [SIZE_W-1:0] in_buff_size,
    input  logic [SIZE_W-1:0] in_median_pos,
    output logic              in_ctrl_rd,
    input  logic              in_pivot_empty,
    input  logic              in_buff_size_empty,
    input  logic              in_median_pos_empty,
    output logic [DATA_W-1:0] out_px,
    output logic              out_px_wr,
    input  logic              out_px_full,
    output logic [DATA_W-1:0] out_pivot,
    output logic [SIZE_W-1:0] out_buff_size,
    output logic [SIZE_W-1:0] out_median_pos,
    output logic              out_found,
    output logic              out_ctrl_wr,
    input  logic              out_pivot_full,
    input  logic              out_buff_size_full,
    input  logic              out_median_pos_full,
    input  logic              out_found_full
);

    localparam int AW = $clog2(BUFF_SIZE);
    localparam logic [AW-1:0]     LAST_ADDR = AW'(BUFF_SIZE - 1);
    localparam logic [SIZE_W-1:0] MAX_SIZE  = SIZE_W'(BUFF_SIZE);
    localparam logic [SIZE_W-1:0] ONE       = SIZE_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        DECIDE,
        EMIT_CTRL,
        EMIT_PX
    } state_t;

    state_t state, state_next;

    logic [DATA_W-1:0] mem [BUFF_SIZE];

    logic [DATA_W-1:0] pivot;
    logic [SIZE_W-1:0] rank;
    logic [SIZE_W-1:0] rem;
    logic [SIZE_W-1:0] n_lt, n_eq, n_gt;
    logic [DATA_W-1:0] lt_min, lt_max, gt_min, gt_max;
    logic [AW-1:0]     rd_ptr;
    logic              emit_gt;

    logic              ctrl_avail, token_room;
    logic [SIZE_W-1:0] size_clip, rank_clip;
    logic [SIZE_W:0]   lt_eq_sum;
    logic [DATA_W:0]   lt_sum, gt_sum;
    logic [AW-1:0]     wr_addr, ptr_step;

    assign ctrl_avail = ~(in_pivot_empty | in_buff_size_empty | in_median_pos_empty);
    assign token_room = ~(out_pivot_full | out_buff_size_full | out_median_pos_full | out_found_full);

    // A zero-size token keeps its rank untouched, so clamping only applies when N > 0.
    assign size_clip = (in_buff_size > MAX_SIZE) ? MAX_SIZE : in_buff_size;
    assign rank_clip = (size_clip == '0) ? in_median_pos :
                       ((in_median_pos > (size_clip - ONE)) ? (size_clip - ONE) : in_median_pos);

    assign lt_eq_sum = {1'b0, n_lt} + {1'b0, n_eq};
    assign lt_sum    = {1'b0, lt_min} + {1'b0, lt_max};
    assign gt_sum    = {1'b0, gt_min} + {1'b0, gt_max};

    // lt region grows up from address 0, gt region grows down from the top.
    assign wr_addr  = (in_px < pivot) ? n_lt[AW-1:0] : (LAST_ADDR - n_gt[AW-1:0]);
    assign ptr_step = emit_gt ? (rd_ptr - AW'(1)) : (rd_ptr + AW'(1));

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and FIFO strobes; everything is held low while in reset.
    always_comb begin
        state_next  = state;
        in_ctrl_rd  = 1'b0;
        in_px_rd    = 1'b0;
        out_ctrl_wr = 1'b0;
        out_px_wr   = 1'b0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    in_ctrl_rd = ctrl_avail;
                    if (ctrl_avail) begin
                        state_next = (size_clip == '0) ? EMIT_CTRL : FILL;
                    end
                end
                FILL: begin
                    in_px_rd = ~in_px_empty;
                    if (!in_px_empty && rem == ONE) begin
                        state_next = DECIDE;
                    end
                end
                DECIDE: begin
                    state_next = EMIT_CTRL;
                end
                EMIT_CTRL: begin
                    out_ctrl_wr = token_room;
                    if (token_room) begin
                        state_next = (out_buff_size != '0) ? EMIT_PX : IDLE;
                    end
                end
                EMIT_PX: begin
                    out_px_wr = ~out_px_full;
                    if (!out_px_full && rem == ONE) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Partition buffer write port; equal pixels are only counted, never stored.
    always_ff @(posedge clock) begin
        if (in_px_rd && (in_px != pivot)) begin
            mem[wr_addr] <= in_px;
        end
    end

    // Token latch, partition counters, min/max trackers, token build and pixel prefetch.
    always_ff @(posedge clock) begin
        if (reset) begin
            pivot          <= '0;
            rank           <= '0;
            rem            <= '0;
            n_lt           <= '0;
            n_eq           <= '0;
            n_gt           <= '0;
            lt_min         <= '0;
            lt_max         <= '0;
            gt_min         <= '0;
            gt_max         <= '0;
            rd_ptr         <= '0;
            emit_gt        <= 1'b0;
            out_px         <= '0;
            out_pivot      <= '0;
            out_buff_size  <= '0;
            out_median_pos <= '0;
            out_found      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_ctrl_rd) begin
                        pivot  <= in_pivot;
                        rem    <= size_clip;
                        rank   <= rank_clip;
                        n_lt   <= '0;
                        n_eq   <= '0;
                        n_gt   <= '0;
                        lt_min <= '1;
                        lt_max <= '0;
                        gt_min <= '1;
                        gt_max <= '0;
                        if (size_clip == '0) begin
                            out_pivot      <= in_pivot;
                            out_buff_size  <= '0;
                            out_median_pos <= in_median_pos;
                            out_found      <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (in_px_rd) begin
                        rem <= rem - ONE;
                        if (in_px < pivot) begin
                            n_lt <= n_lt + ONE;
                            if (in_px < lt_min) lt_min <= in_px;
                            if (in_px > lt_max) lt_max <= in_px;
                        end else if (in_px == pivot) begin
                            n_eq <= n_eq + ONE;
                        end else begin
                            n_gt <= n_gt + ONE;
                            if (in_px < gt_min) gt_min <= in_px;
                            if (in_px > gt_max) gt_max <= in_px;
                        end
                    end
                end
                DECIDE: begin
                    if (rank < n_lt) begin
                        out_pivot      <= lt_sum[DATA_W:1];
                        out_buff_size  <= n_lt;
                        out_median_pos <= rank;
                        out_found      <= 1'b0;
                        emit_gt        <= 1'b0;
                        rd_ptr         <= '0;
                        rem            <= n_lt;
                    end else if ({1'b0, rank} < lt_eq_sum) begin
                        out_pivot      <= pivot;
                        out_buff_size  <= '0;
                        out_median_pos <= '0;
                        out_found      <= 1'b1;
                    end else begin
                        out_pivot      <= gt_sum[DATA_W:1];
                        out_buff_size  <= n_gt;
                        out_median_pos <= rank - n_lt - n_eq;
                        out_found      <= 1'b0;
                        emit_gt        <= 1'b1;
                        rd_ptr         <= LAST_ADDR;
                        rem            <= n_gt;
                    end
                end
                EMIT_CTRL: begin
                    out_px <= mem[rd_ptr];
                    if (out_ctrl_wr && out_buff_size != '0) begin
                        rd_ptr <= ptr_step;
                    end
                end
                EMIT_PX: begin
                    if (out_px_wr) begin
                        rem <= rem - ONE;
                        if (rem != ONE) begin
                            out_px <= mem[rd_ptr];
                            rd_ptr <= ptr_step;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_median_partition_stage.sv
// Directed bench for median_partition_stage with DATA_W=8, BUFF_SIZE=8.
module tb_median_partition_stage;

    localparam int DATA_W    = 8;
    localparam int BUFF_SIZE = 8;
    localparam int SIZE_W    = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_px = '0;
    logic              in_px_rd;
    logic              in_px_empty = 1'b1;
    logic [DATA_W-1:0] in_pivot = '0;
    logic [SIZE_W-1:0] in_buff_size = '0;
    logic [SIZE_W-1:0] in_median_pos = '0;
    logic              in_ctrl_rd;
    logic              in_pivot_empty = 1'b1;
    logic              in_buff_size_empty = 1'b1;
    logic              in_median_pos_empty = 1'b1;
    logic [DATA_W-1:0] out_px;
    logic              out_px_wr;
    logic              out_px_full = 1'b0;
    logic [DATA_W-1:0] out_pivot;
    logic [SIZE_W-1:0] out_buff_size;
    logic [SIZE_W-1:0] out_median_pos;
    logic              out_found;
    logic              out_ctrl_wr;
    logic              out_pivot_full = 1'b0;
    logic              out_buff_size_full = 1'b0;
    logic              out_median_pos_full = 1'b0;
    logic              out_found_full = 1'b0;

    median_partition_stage #(
        .DATA_W   (DATA_W),
        .BUFF_SIZE(BUFF_SIZE),
        .SIZE_W   (SIZE_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .in_px              (in_px),
        .in_px_rd           (in_px_rd),
        .in_px_empty        (in_px_empty),
        .in_pivot           (in_pivot),
        .in_buff_size       (in_buff_size),
        .in_median_pos      (in_median_pos),
        .in_ctrl_rd         (in_ctrl_rd),
        .in_pivot_empty     (in_pivot_empty),
        .in_buff_size_empty (in_buff_size_empty),
        .in_median_pos_empty(in_median_pos_empty),
        .out_px             (out_px),
        .out_px_wr          (out_px_wr),
        .out_px_full        (out_px_full),
        .out_pivot          (out_pivot),
        .out_buff_size      (out_buff_size),
        .out_median_pos     (out_median_pos),
        .out_found          (out_found),
        .out_ctrl_wr        (out_ctrl_wr),
        .out_pivot_full     (out_pivot_full),
        .out_buff_size_full (out_buff_size_full),
        .out_median_pos_full(out_median_pos_full),
        .out_found_full     (out_found_full)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  px_q[$];
    logic [15:0] ctrl_q[$];
    logic [7:0]  got_px[$];
    logic [16:0] got_tok[$];

    logic stall_en       = 1'b0;
    logic pend_px_pop    = 1'b0;
    logic pend_ctrl_pop  = 1'b0;
    int   cyc            = 0;
    int   px_pops        = 0;
    int   px_rd_seen     = 0;
    int   rst_strobe_err = 0;
    int   pop_cyc        = 0;
    int   push_cyc       = 0;

    logic [7:0] pix [8] = '{8'd10, 8'd200, 8'd127, 8'd50, 8'd127, 8'd90, 8'd250, 8'd30};

    // FIFO models: present heads and flags on the falling edge, then record
    // which handshakes will complete at the next rising edge.
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (pend_px_pop && px_q.size() > 0) void'(px_q.pop_front());
        if (pend_ctrl_pop && ctrl_q.size() > 0) void'(ctrl_q.pop_front());
        in_px_empty         = (px_q.size() == 0) || (stall_en && (cyc % 3 == 0));
        in_px               = (px_q.size() != 0) ? px_q[0] : 8'h00;
        in_pivot_empty      = (ctrl_q.size() == 0);
        in_buff_size_empty  = (ctrl_q.size() == 0);
        in_median_pos_empty = (ctrl_q.size() == 0);
        {in_pivot, in_buff_size, in_median_pos} = (ctrl_q.size() != 0) ? ctrl_q[0] : 16'h0000;
        out_px_full    = stall_en && (cyc % 2 == 1);
        out_pivot_full = stall_en && (cyc % 2 == 0);
        #1;
        pend_px_pop   = in_px_rd && !in_px_empty;
        pend_ctrl_pop = in_ctrl_rd && !(in_pivot_empty || in_buff_size_empty || in_median_pos_empty);
        if (pend_px_pop) px_pops = px_pops + 1;
        if (pend_ctrl_pop) pop_cyc = cyc;
        if (in_px_rd) px_rd_seen = px_rd_seen + 1;
        if (out_px_wr && !out_px_full) got_px.push_back(out_px);
        if (out_ctrl_wr && !(out_pivot_full || out_buff_size_full || out_median_pos_full || out_found_full)) begin
            got_tok.push_back({out_pivot, out_buff_size, out_median_pos, out_found});
            push_cyc = cyc;
        end
        if (reset && (in_ctrl_rd || in_px_rd || out_ctrl_wr || out_px_wr)) rst_strobe_err = rst_strobe_err + 1;
    end

    task automatic start_token(input logic [7:0] p, input logic [3:0] n, input logic [3:0] k, input int npx);
        got_px.delete();
        got_tok.delete();
        ctrl_q.push_back({p, n, k});
        for (int i = 0; i < npx; i++) px_q.push_back(pix[i]);
    endtask

    task automatic wait_outputs(input int exp_n, output logic timed_out);
        int n;
        n = 0;
        timed_out = 1'b0;
        while (!(got_tok.size() >= 1 && got_px.size() >= exp_n)) begin
            @(posedge clock); #1;
            n++;
            if (n > 300) begin
                timed_out = 1'b1;
                break;
            end
        end
        repeat (6) @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if ({in_ctrl_rd, in_px_rd, out_ctrl_wr, out_px_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000", {in_ctrl_rd, in_px_rd, out_ctrl_wr, out_px_wr});
        end
        n_checks++;
        if ({out_pivot, out_buff_size, out_median_pos, out_found} !== 17'h0) begin
            n_fail++;
            $display("FAIL reset_token_regs: got %h want 0", {out_pivot, out_buff_size, out_median_pos, out_found});
        end
        n_checks++;
        if (out_px !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_out_px: got %0d want 0", out_px);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_found(input string tag);
        logic to;
        @(posedge clock); #1;
        start_token(8'd127, 4'd8, 4'd4, 8);
        wait_outputs(0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %0b want 0", tag, to); end
        n_checks++;
        if (got_tok.size() != 1) begin n_fail++; $display("FAIL %s_tok_count: got %0d want 1", tag, got_tok.size()); end
        n_checks++;
        if (got_tok[0] !== {8'd127, 4'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL %s_token: got %h want %h", tag, got_tok[0], {8'd127, 4'd0, 4'd0, 1'b1});
        end
        n_checks++;
        if (got_px.size() != 0) begin n_fail++; $display("FAIL %s_px_count: got %0d want 0", tag, got_px.size()); end
        n_checks++;
        if (push_cyc - pop_cyc != 10) begin n_fail++; $display("FAIL %s_latency: got %0d want 10", tag, push_cyc - pop_cyc); end
    endtask

    task automatic test_lt_region(input string tag);
        logic to;
        logic [7:0] exp_px [4] = '{8'd10, 8'd50, 8'd90, 8'd30};
        @(posedge clock); #1;
        start_token(8'd100, 4'd8, 4'd1, 8);
        wait_outputs(4, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %0b want 0", tag, to); end
        n_checks++;
        if (got_tok.size() != 1) begin n_fail++; $display("FAIL %s_tok_count: got %0d want 1", tag, got_tok.size()); end
        n_checks++;
        if (got_tok[0] !== {8'd50, 4'd4, 4'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_token: got %h want %h", tag, got_tok[0], {8'd50, 4'd4, 4'd1, 1'b0});
        end
        n_checks++;
        if (got_px.size() != 4) begin n_fail++; $display("FAIL %s_px_count: got %0d want 4", tag, got_px.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_px[i] !== exp_px[i]) begin
                n_fail++;
                $display("FAIL %s_px%0d: got %0d want %0d", tag, i, got_px[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_gt_region(input string tag, input logic [3:0] size_in, input logic [3:0] rank_in,
                                  input logic [3:0] rank_out);
        logic to;
        logic [7:0] exp_px [4] = '{8'd200, 8'd127, 8'd127, 8'd250};
        @(posedge clock); #1;
        start_token(8'd100, size_in, rank_in, 8);
        wait_outputs(4, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: got %0b want 0", tag, to); end
        n_checks++;
        if (got_tok[0] !== {8'd188, 4'd4, rank_out, 1'b0}) begin
            n_fail++;
            $display("FAIL %s_token: got %h want %h", tag, got_tok[0], {8'd188, 4'd4, rank_out, 1'b0});
        end
        n_checks++;
        if (got_px.size() != 4) begin n_fail++; $display("FAIL %s_px_count: got %0d want 4", tag, got_px.size()); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (got_px[i] !== exp_px[i]) begin
                n_fail++;
                $display("FAIL %s_px%0d: got %0d want %0d", tag, i, got_px[i], exp_px[i]);
            end
        end
    endtask

    task automatic test_solved_token();
        logic to;
        int rd_base;
        @(posedge clock); #1;
        rd_base = px_rd_seen;
        start_token(8'd77, 4'd0, 4'd0, 2);
        wait_outputs(0, to);
        n_checks++;
        if (to !== 1'b0) begin n_fail++; $display("FAIL solved_timeout: got %0b want 0", to); end
        n_checks++;
        if (got_tok[0] !== {8'd77, 4'd0, 4'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL solved_token: got %h want %h", got_tok[0], {8'd77, 4'd0, 4'd0, 1'b1});
        end
        n_checks++;
        if (px_rd_seen - rd_base != 0) begin n_fail++; $display("FAIL solved_px_rd: got %0d want 0", px_rd_seen - rd_base); end
        n_checks++;
        if (px_q.size() != 2) begin n_fail++; $display("FAIL solved_px_left: got %0d want 2", px_q.size()); end
        px_q.delete();
        @(posedge clock); #1;
    endtask

    task automatic test_stalls();
        stall_en = 1'b1;
        test_lt_region("stall");
        stall_en = 1'b0;
        n_checks++;
        if (got_tok.size() != 1) begin n_fail++; $display("FAIL stall_tok_count: got %0d want 1", got_tok.size()); end
        @(posedge clock); #1;
    endtask

    task automatic test_reset_mid_fill();
        int base_pops;
        int base_err;
        int n;
        @(posedge clock); #1;
        base_pops = px_pops;
        base_err  = rst_strobe_err;
        start_token(8'd127, 4'd8, 4'd4, 8);
        n = 0;
        while (px_pops - base_pops < 3 && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        px_q.delete();
        ctrl_q.delete();
        n_checks++;
        if (px_pops - base_pops != 3) begin n_fail++; $display("FAIL midreset_pops: got %0d want 3", px_pops - base_pops); end
        n_checks++;
        if (rst_strobe_err != base_err) begin n_fail++; $display("FAIL midreset_strobes: got %0d want 0", rst_strobe_err - base_err); end
        n_checks++;
        if ({out_pivot, out_buff_size, out_median_pos, out_found} !== 17'h0) begin
            n_fail++;
            $display("FAIL midreset_token_regs: got %h want 0", {out_pivot, out_buff_size, out_median_pos, out_found});
        end
        n_checks++;
        if (got_tok.size() != 0) begin n_fail++; $display("FAIL midreset_tok_count: got %0d want 0", got_tok.size()); end
        reset = 1'b0;
        @(posedge clock); #1;
        test_found("after_reset");
    endtask

    initial begin
        test_reset();
        test_found("found");
        test_lt_region("lt");
        test_gt_region("gt", 4'd8, 4'd6, 4'd2);
        test_solved_token();
        test_stalls();
        test_gt_region("clip", 4'd15, 4'd15, 4'd3);
        test_reset_mid_fill();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
